// File: rtl/aline_capture_buffer.sv
// aline_capture_buffer: ping-pong A-line capture buffer between a free-running ADC and a
// valid/ready sample stream. Two banks alternate between capture and drain.
// Optional feature macro: ALINE_OVF_COUNT_EN (saturating dropped-line counter on ovf_count).
module aline_capture_buffer #(
  parameter logic [10:0] NSAMPLES = 11'd1170,
  parameter int unsigned DATA_W   = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              sweep_trig,
  input  logic [10:0]       addr,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              overflow,
  output logic [15:0]       ovf_count
);

  localparam int unsigned Depth   = int'(NSAMPLES);
  localparam int unsigned AW      = $clog2(Depth);
  localparam logic [10:0] LastAdr = NSAMPLES - 11'd1;
  localparam logic [AW-1:0] LastIdx = AW'(Depth - 1);

  typedef enum logic [1:0] {BankEmpty, BankFilling, BankFull, BankDraining} bank_st_e;
  typedef enum logic {WrIdle, WrCapture} wr_st_e;
  typedef enum logic {RdIdle, RdStream} rd_st_e;

  bank_st_e bank_q [2];
  bank_st_e bank_d [2];

  wr_st_e wr_state_q, wr_state_d;
  logic   wr_bank_q, wr_bank_d;
  logic   wr_start, wr_en, wr_done, ovf_d;

  rd_st_e        rd_state_q, rd_state_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] rd_ptr_q;
  logic          fetch_done_q;
  logic          rd_start, fetch, rel_any;

  logic          oldest_q;
  logic [1:0]    full, avail;
  logic          pick;
  logic          addr_ok, addr_last;

  logic [DATA_W-1:0] mem [2][Depth];

  assign addr_ok   = addr < NSAMPLES;
  assign addr_last = addr == LastAdr;
  assign full      = {bank_q[1] == BankFull, bank_q[0] == BankFull};
  // A bank released by the reader this cycle is already usable by the writer.
  assign avail     = {bank_q[1] == BankEmpty || (rel_any && rd_bank_q == 1'b1),
                      bank_q[0] == BankEmpty || (rel_any && rd_bank_q == 1'b0)};
  assign pick      = (&full) ? oldest_q : ~full[0];

  // ---------------- write side ----------------

  // Write FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_state_q <= WrIdle;
      wr_bank_q  <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_bank_q  <= wr_bank_d;
    end
  end

  // Write FSM next state: start on trigger if a bank is free, finish on the last address.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_bank_d  = wr_bank_q;
    case (wr_state_q)
      WrIdle: begin
        if (sweep_trig && (|avail)) begin
          wr_state_d = WrCapture;
          wr_bank_d  = avail[0] ? 1'b0 : 1'b1;
        end
      end
      WrCapture: begin
        if (!sweep_trig && addr_last) wr_state_d = WrIdle;
      end
      default: wr_state_d = WrIdle;
    endcase
  end

  // Write FSM outputs: the trigger cycle's sample is captured too.
  always_comb begin
    wr_start = 1'b0;
    wr_en    = 1'b0;
    wr_done  = 1'b0;
    ovf_d    = 1'b0;
    case (wr_state_q)
      WrIdle: begin
        if (sweep_trig) begin
          if (|avail) begin
            wr_start = 1'b1;
            wr_en    = addr_ok;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      WrCapture: begin
        wr_en   = addr_ok;
        wr_done = addr_last && !sweep_trig;
      end
      default: ;
    endcase
  end

  // Sample memory; contents survive reset, only bank states are cleared.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_bank_d][addr[AW-1:0]] <= adc_data;
  end

  // ---------------- bank bookkeeping ----------------

  // Bank state next value; write events override read release on the same bank.
  always_comb begin
    bank_d = bank_q;
    if (rd_start) bank_d[rd_bank_d] = BankDraining;
    if (rel_any)  bank_d[rd_bank_q] = BankEmpty;
    if (wr_start) bank_d[wr_bank_d] = BankFilling;
    if (wr_done)  bank_d[wr_bank_q] = BankFull;
  end

  // Bank states and the fill-order tracker used when both banks are FULL.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bank_q[0] <= BankEmpty;
      bank_q[1] <= BankEmpty;
      oldest_q  <= 1'b0;
    end else begin
      bank_q <= bank_d;
      if (wr_done) oldest_q <= full[~wr_bank_q] ? ~wr_bank_q : wr_bank_q;
    end
  end

  // ---------------- read side ----------------

  // Read FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_state_q <= RdIdle;
      rd_bank_q  <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_bank_q  <= rd_bank_d;
    end
  end

  // Read FSM next state: claim the oldest FULL bank, return idle after the last transfer.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    case (rd_state_q)
      RdIdle: begin
        if (|full) begin
          rd_state_d = RdStream;
          rd_bank_d  = pick;
        end
      end
      RdStream: begin
        if (rel_any) rd_state_d = RdIdle;
      end
      default: rd_state_d = RdIdle;
    endcase
  end

  // Read FSM outputs: fetch whenever the output register is empty or being consumed.
  always_comb begin
    rd_start = 1'b0;
    fetch    = 1'b0;
    rel_any  = 1'b0;
    case (rd_state_q)
      RdIdle:   rd_start = |full;
      RdStream: begin
        fetch   = !fetch_done_q && (!rd_valid || rd_ready);
        rel_any = rd_valid && rd_ready && rd_last;
      end
      default: ;
    endcase
  end

  // Read pointer and registered output stage (memory read register doubles as output).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q     <= '0;
      fetch_done_q <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      rd_last      <= 1'b0;
    end else begin
      if (rd_start) begin
        rd_ptr_q     <= '0;
        fetch_done_q <= 1'b0;
      end else if (fetch) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        if (rd_ptr_q == LastIdx) fetch_done_q <= 1'b1;
      end
      if (fetch) begin
        rd_valid <= 1'b1;
        rd_data  <= mem[rd_bank_q][rd_ptr_q];
        rd_last  <= rd_ptr_q == LastIdx;
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end
    end
  end

  // ---------------- overflow ----------------

  // Registered one-cycle pulse for a dropped line.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) overflow <= 1'b0;
    else          overflow <= ovf_d;
  end

`ifdef ALINE_OVF_COUNT_EN
  logic [15:0] ovf_cnt_q;

  // Saturating dropped-line counter, advanced together with the overflow pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                          ovf_cnt_q <= '0;
    else if (ovf_d && ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
  end

  assign ovf_count = ovf_cnt_q;
`else
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_aline_capture_buffer.sv
// Directed self-checking bench for aline_capture_buffer with NSAMPLES=8.
module tb_aline_capture_buffer;

  localparam int NS = 8;
  localparam int DW = 16;
`ifdef ALINE_OVF_COUNT_EN
  localparam int ExpOvf = 1;
`else
  localparam int ExpOvf = 0;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          sweep_trig = 1'b0;
  logic [10:0]   addr = '0;
  logic [DW-1:0] adc_data = '0;
  logic          rd_ready = 1'b0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          overflow;
  logic [15:0]   ovf_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] rdy_pat = 4'b1001;

  aline_capture_buffer #(
    .NSAMPLES(11'd8),
    .DATA_W  (DW)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .sweep_trig(sweep_trig),
    .addr      (addr),
    .adc_data  (adc_data),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .overflow  (overflow),
    .ovf_count (ovf_count)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive addresses 0..n-1 with data base+addr, trigger on address 0.
  task automatic cap(input int base, input int n);
    for (int a = 0; a < n; a++) begin
      sweep_trig = (a == 0);
      addr       = 11'(a);
      adc_data   = DW'(base + a);
      tick();
    end
    sweep_trig = 1'b0;
    addr       = '0;
  endtask

  // Consume one line, checking order, rd_last, and stability across stalls.
  task automatic read_line(input string tag, input int base, input int max_cyc, input bit toggle);
    int got;
    int cyc;
    bit stalled;
    logic [DW-1:0] held;
    logic rdy;
    got = 0;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    while (got < NS && cyc < max_cyc) begin
      rdy = toggle ? rdy_pat[cyc % 4] : 1'b1;
      rd_ready = rdy;
      if (stalled) begin
        chk({tag, "_stall_valid"}, 32'(rd_valid), 32'd1);
        chk({tag, "_stall_data"}, 32'(rd_data), 32'(held));
      end
      if (rd_valid && rdy) begin
        chk({tag, "_data"}, 32'(rd_data), 32'(base + got));
        chk({tag, "_last"}, 32'(rd_last), 32'(got == NS - 1));
        got++;
      end
      stalled = rd_valid && !rdy;
      held = rd_data;
      tick();
      cyc++;
    end
    chk({tag, "_count"}, 32'(got), 32'(NS));
    rd_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    chk("rst_last", 32'(rd_last), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_cnt", 32'(ovf_count), 32'd0);
    reset_n = 1'b1;
    tick();

    // Basic line with rd_ready high
    cap(100, 9);
    read_line("basic", 100, 40, 1'b0);
    rd_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("basic_idle", 32'(rd_valid), 32'd0);
    rd_ready = 1'b0;

    // Stalled stream with rd_ready 1,0,0,1
    cap(200, 9);
    read_line("stall", 200, 80, 1'b1);

    // Three triggers ten cycles apart with reader blocked
    cap(300, 10);
    cap(400, 10);
    chk("ovf_line2", 32'(overflow), 32'd0);
    sweep_trig = 1'b1;
    addr       = '0;
    adc_data   = 16'd500;
    tick();
    sweep_trig = 1'b0;
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_cnt", 32'(ovf_count), 32'(ExpOvf));
    tick();
    chk("ovf_one_cycle", 32'(overflow), 32'd0);
    read_line("ovf_l1", 300, 40, 1'b0);
    read_line("ovf_l2", 400, 40, 1'b0);
    chk("ovf_cnt_hold", 32'(ovf_count), 32'(ExpOvf));

    // Retrigger mid-capture
    for (int a = 0; a < 4; a++) begin
      sweep_trig = (a == 0);
      addr       = 11'(a);
      adc_data   = DW'(600 + a);
      tick();
    end
    sweep_trig = 1'b1;
    addr       = '0;
    adc_data   = 16'd700;
    tick();
    chk("retrig_ovf", 32'(overflow), 32'd0);
    for (int a = 1; a < 9; a++) begin
      sweep_trig = 1'b0;
      addr       = 11'(a);
      adc_data   = DW'(700 + a);
      tick();
    end
    addr = '0;
    chk("retrig_ovf2", 32'(overflow), 32'd0);
    read_line("retrig", 700, 40, 1'b0);

    // Reset in the middle of a capture
    for (int a = 0; a < 5; a++) begin
      sweep_trig = (a == 0);
      addr       = 11'(a);
      adc_data   = DW'(800 + a);
      tick();
    end
    sweep_trig = 1'b0;
    addr       = 11'd5;
    reset_n    = 1'b0;
    #1;
    chk("midrst_valid0", 32'(rd_valid), 32'd0);
    tick();
    chk("midrst_valid1", 32'(rd_valid), 32'd0);
    tick();
    chk("midrst_valid2", 32'(rd_valid), 32'd0);
    reset_n = 1'b1;
    addr    = '0;
    tick();
    cap(900, 9);
    read_line("postrst", 900, 40, 1'b0);

    // Both banks full; trigger coincides with the rd_last transfer
    cap(1000, 9);
    cap(1100, 9);
    tick();
    chk("both_valid", 32'(rd_valid), 32'd1);
    rd_ready = 1'b1;
    for (int k = 0; k < NS; k++) begin
      chk("coinc_data", 32'(rd_data), 32'(1000 + k));
      chk("coinc_last", 32'(rd_last), 32'(k == NS - 1));
      sweep_trig = (k == NS - 1);
      addr       = '0;
      adc_data   = 16'd1200;
      tick();
    end
    sweep_trig = 1'b0;
    rd_ready   = 1'b0;
    chk("coinc_ovf", 32'(overflow), 32'd0);
    for (int a = 1; a < 9; a++) begin
      addr     = 11'(a);
      adc_data = DW'(1200 + a);
      tick();
    end
    addr = '0;
    chk("coinc_ovf2", 32'(overflow), 32'd0);
    read_line("coinc_b1", 1100, 40, 1'b0);
    read_line("coinc_b0", 1200, 40, 1'b0);
    chk("final_cnt", 32'(ovf_count), 32'(ExpOvf));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
